// File: rtl/tx_pkg.sv
// tx_pkg: shared state encodings and symbol constants for the QPSK framer.
package tx_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SYNC = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_TAIL = 3'd4;
  localparam logic [1:0] PRE_A = 2'b01;
  localparam logic [1:0] PRE_B = 2'b10;
  localparam logic [1:0] TAIL_SYM = 2'b00;
  localparam logic [15:0] DEF_SYNC_WORD = 16'hD391;
  localparam int SYMS_PER_BYTE = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; pushes when full and pops when empty are dropped.
module sync_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign head_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  always_ff @(posedge clk) if (do_push) mem_q[wptr_q] <= wdata_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= do_pop ? rptr_q + 1'b1 : rptr_q;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/tx_symbol_framer.sv
// tx_symbol_framer: frames FIFO'd payload bytes as preamble/sync/payload/tail and
// serialises them MSB-first into 2-bit QPSK symbols, one strobe every SPS clocks.
module tx_symbol_framer import tx_pkg::*; #(
  parameter int          SPS          = 8,
  parameter int          PREAMBLE_LEN = 16,
  parameter logic [15:0] SYNC_WORD    = DEF_SYNC_WORD,
  parameter int          TAIL_LEN     = 5,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  output logic       tx_busy,
  output logic       underrun
);
  logic [2:0] state_q, state_d;
  logic [7:0] tick_q, tick_d, idx_q, idx_d, byte_q, byte_d;
  logic last_q, last_d, ur_q, ur_set, pop, boundary, tick_end;
  logic [1:0] sym_q, sym_new;
  logic [15:0] sw;
  logic [8:0] head;
  logic full, empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  sync_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(in_valid), .wdata_i({in_last, in_data}),
    .pop_i(pop), .head_o(head), .full_o(full), .empty_o(empty), .count_o(fifo_count)
  );
  assign in_ready = !full;
  assign sym_valid = boundary;
  assign sym_out = boundary ? sym_new : sym_q;
  assign tx_busy = state_q != ST_IDLE;
  assign underrun = ur_q | ur_set;
  // state_q/idx_q name the symbol that the next boundary will emit
  always_comb begin
    boundary = state_q != ST_IDLE && tick_q == '0;
    tick_end = tick_q == 8'(SPS-1);
    state_d = state_q;
    idx_d = idx_q;
    byte_d = byte_q;
    last_d = last_q;
    pop = 1'b0;
    ur_set = 1'b0;
    sym_new = sym_q;
    sw = SYNC_WORD << {idx_q[2:0], 1'b0};
    if (state_q == ST_IDLE) begin
      state_d = fifo_count != '0 ? ST_PRE : ST_IDLE;
      idx_d = '0;
    end else if (boundary) begin
      case (state_q)
        ST_PRE: begin
          sym_new = idx_q[0] ? PRE_B : PRE_A;
          state_d = idx_q == 8'(PREAMBLE_LEN-1) ? ST_SYNC : ST_PRE;
          idx_d = idx_q == 8'(PREAMBLE_LEN-1) ? '0 : idx_q + 8'd1;
        end
        ST_SYNC: begin
          sym_new = sw[15:14];
          state_d = idx_q == 8'd7 ? ST_PAY : ST_SYNC;
          idx_d = idx_q == 8'd7 ? '0 : idx_q + 8'd1;
        end
        ST_PAY: begin
          if (idx_q == '0) begin
            pop = !empty;
            ur_set = empty;
            sym_new = empty ? TAIL_SYM : head[7:6];
            state_d = empty ? ST_TAIL : ST_PAY;
            byte_d = {head[5:0], 2'b00};
            last_d = head[8];
            idx_d = 8'd1;
          end else begin
            sym_new = byte_q[7:6];
            byte_d = {byte_q[5:0], 2'b00};
            state_d = idx_q == 8'(SYMS_PER_BYTE-1) && last_q ? ST_TAIL : ST_PAY;
            idx_d = idx_q == 8'(SYMS_PER_BYTE-1) ? '0 : idx_q + 8'd1;
          end
        end
        default: begin
          sym_new = TAIL_SYM;
          idx_d = idx_q + 8'd1;
        end
      endcase
    end else if (state_q == ST_TAIL && tick_end && idx_q == 8'(TAIL_LEN)) begin
      state_d = ST_IDLE;
      idx_d = '0;
    end
    tick_d = (state_q == ST_IDLE || state_d == ST_IDLE || tick_end) ? '0 : tick_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q <= '0;
      idx_q <= '0;
      byte_q <= '0;
      last_q <= 1'b0;
      sym_q <= '0;
      ur_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      idx_q <= idx_d;
      byte_q <= byte_d;
      last_q <= last_d;
      sym_q <= sym_out;
      ur_q <= underrun;
    end
  end
endmodule

// File: tb/tb_tx_symbol_framer.sv
// tb_tx_symbol_framer: directed frames with hand-computed symbol streams for tx_symbol_framer.
module tb_tx_symbol_framer;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, sym_valid, tx_busy, underrun;
  logic [1:0] sym_out;
  int errors = 0, checks = 0, cyc = 0, busy_n = 0;
  logic [1:0] sq[$];
  int tq[$];
  logic uq[$];
  logic [1:0] eq[$];
  localparam logic [1:0] SYNC_SYMS [8] = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01};
  tx_symbol_framer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sym_out(sym_out), .sym_valid(sym_valid), .tx_busy(tx_busy), .underrun(underrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_busy) busy_n <= busy_n + 1;
    if (sym_valid) begin
      sq.push_back(sym_out);
      tq.push_back(cyc);
      uq.push_back(underrun);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d, input logic l);
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_frame(input string tag);
    int n = 0;
    bit seen = 0;
    while (n < 3000 && !(seen && !tx_busy)) begin
      if (tx_busy) seen = 1;
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(n < 3000), 1);
  endtask
  task automatic wait_syms(input string tag, input int target);
    int n = 0;
    while (n < 3000 && sq.size() < target) begin
      step();
      n++;
    end
    chk({tag, "_reach"}, 32'(sq.size() >= target), 1);
  endtask
  task automatic exp_head();
    eq.delete();
    for (int i = 0; i < 16; i++) eq.push_back(i % 2 ? 2'b10 : 2'b01);
    for (int i = 0; i < 8; i++) eq.push_back(SYNC_SYMS[i]);
  endtask
  task automatic exp_add(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) eq.push_back(s);
  endtask
  task automatic check_frame(input string tag, input int base, input int bbase, input int exp_busy);
    int bad = 0;
    chk({tag, "_nsym"}, sq.size() - base, eq.size());
    for (int i = 0; i < eq.size() && base + i < sq.size(); i++)
      chk($sformatf("%s_sym%0d", tag, i), 32'(sq[base+i]), 32'(eq[i]));
    for (int i = base + 1; i < tq.size(); i++) if (tq[i] - tq[i-1] != 8) bad++;
    chk({tag, "_gap"}, bad, 0);
    chk({tag, "_busy"}, busy_n - bbase, exp_busy);
  endtask
  initial begin
    int base, bb, acc;
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 32'(sym_valid), 0);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_sym", 32'(sym_out), 0);
    base = sq.size();
    repeat (100) step();
    chk("idle_strobes", sq.size() - base, 0);
    // single byte B4
    base = sq.size();
    bb = busy_n;
    push(8'hB4, 1'b1);
    wait_frame("b4");
    exp_head();
    eq.push_back(2'b10); eq.push_back(2'b11); eq.push_back(2'b01); eq.push_back(2'b00);
    exp_add(2'b00, 5);
    check_frame("b4", base, bb, 264);
    if (sq.size() > base + 24) chk("b4_latency", tq[base+24] - tq[base], 192);
    else chk("b4_latency", 0, 1);
    // three bytes
    base = sq.size();
    bb = busy_n;
    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    push(8'h1B, 1'b1);
    wait_frame("three");
    exp_head();
    exp_add(2'b00, 4);
    exp_add(2'b11, 4);
    eq.push_back(2'b00); eq.push_back(2'b01); eq.push_back(2'b10); eq.push_back(2'b11);
    exp_add(2'b00, 5);
    check_frame("three", base, bb, 328);
    repeat (20) step();
    chk("three_idle", 32'(tx_busy), 0);
    // underrun
    base = sq.size();
    bb = busy_n;
    push(8'hAA, 1'b0);
    wait_frame("ur");
    exp_head();
    exp_add(2'b10, 4);
    exp_add(2'b00, 5);
    check_frame("ur", base, bb, 264);
    if (sq.size() > base + 28) begin
      chk("ur_before", 32'(uq[base+27]), 0);
      chk("ur_at", 32'(uq[base+28]), 1);
    end else chk("ur_at", 0, 1);
    repeat (20) step();
    chk("ur_sticky", 32'(underrun), 1);
    chk("ur_idle", 32'(tx_busy), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ur_cleared", 32'(underrun), 0);
    // full FIFO
    base = sq.size();
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'h30 + 8'(i);
      in_last = (i == 15);
      in_valid = 1'b1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("full_accepted", acc, 16);
    chk("full_ready_low", 32'(in_ready), 0);
    wait_syms("full_pop", base + 25);
    chk("full_ready_at_pop", 32'(in_ready), 0);
    if (sq.size() > base + 24) chk("full_first_pay", 32'(sq[base+24]), 0);
    step();
    chk("full_ready_after_pop", 32'(in_ready), 1);
    wait_frame("full");
    chk("full_nsym", sq.size() - base, 93);
    repeat (30) step();
    chk("full_no_17th", 32'(tx_busy), 0);
    // reset mid-payload
    base = sq.size();
    push(8'h12, 1'b0);
    push(8'h34, 1'b1);
    wait_syms("mid", base + 26);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_valid", 32'(sym_valid), 0);
    chk("mid_busy", 32'(tx_busy), 0);
    chk("mid_ready", 32'(in_ready), 1);
    base = sq.size();
    repeat (20) step();
    chk("mid_fifo_empty", sq.size() - base, 0);
    chk("mid_idle", 32'(tx_busy), 0);
    base = sq.size();
    push(8'h5A, 1'b1);
    wait_frame("fresh");
    if (sq.size() > base) chk("fresh_first", 32'(sq[base]), 32'(2'b01));
    else chk("fresh_first", 0, 1);
    chk("fresh_nsym", sq.size() - base, 33);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
